tor_slot_sync: RTL and testbench

TOR_SLOT_SYNC -- requirements
Module: tor_slot_sync

---
 rtl/ocs_ctrl_pkg.sv | 17 +
 rtl/tor_ctrl_parser.sv | 63 ++++++
 rtl/tor_slot_sync.sv | 128 ++++++++++++
 tb/tb_tor_slot_sync.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/ocs_ctrl_pkg.sv
// ocs_ctrl_pkg: control-channel constants and slot state encoding shared by
// the ToR slot synchroniser and the OCS controller.
package ocs_ctrl_pkg;

    localparam logic [15:0] ETH_TYPE_OCS  = 16'h88B5;
    localparam logic [7:0]  CMD_SIM_START = 8'h01;
    localparam logic [7:0]  CMD_TIME_SYNC = 8'h02;
    localparam logic [47:0] MAC_BCAST     = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_GUARD,
        ST_WAIT_SYNC
    } slot_state_e;

endpackage

// File: rtl/tor_ctrl_parser.sv
// tor_ctrl_parser: walks control frames beat by beat and emits a one-cycle
// command strobe, combinationally on the last beat of an accepted frame.
module tor_ctrl_parser
    import ocs_ctrl_pkg::*;
#(
    parameter logic [47:0] P_MY_TOR_MAC = 48'h8D_BC_5C_4A_00_00
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [63:0] i_data,
    input  logic        i_valid,
    input  logic        i_last,
    output logic        o_cmd_vld,
    output logic [7:0]  o_cmd,
    output logic [7:0]  o_slot_id
);

    logic [1:0] beat_q, beat_d;
    logic       match_q, match_d;
    logic [7:0] cmd_q, cmd_d;
    logic [7:0] id_q, id_d;
    logic       beat0_ok;

    assign beat0_ok = (i_data[63:16] == P_MY_TOR_MAC || i_data[63:16] == MAC_BCAST) &&
                      i_data[15:0] == ETH_TYPE_OCS;

    always_comb begin
        beat_d  = beat_q;
        match_d = match_q;
        cmd_d   = cmd_q;
        id_d    = id_q;
        if (i_valid) begin
            beat_d = i_last ? 2'd0 : (beat_q == 2'd2 ? 2'd2 : beat_q + 2'd1);
            if (beat_q == 2'd0)
                match_d = beat0_ok;
            if (beat_q == 2'd1) begin
                cmd_d = i_data[63:56];
                id_d  = i_data[55:48];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            beat_q  <= 2'd0;
            match_q <= 1'b0;
            cmd_q   <= 8'h00;
            id_q    <= 8'h00;
        end else begin
            beat_q  <= beat_d;
            match_q <= match_d;
            cmd_q   <= cmd_d;
            id_q    <= id_d;
        end
    end

    // A 2-beat frame ends on beat1, so cmd/id come straight off the bus then.
    assign o_cmd     = beat_q == 2'd1 ? i_data[63:56] : cmd_q;
    assign o_slot_id = beat_q == 2'd1 ? i_data[55:48] : id_q;
    assign o_cmd_vld = i_valid && i_last && beat_q != 2'd0 && match_q &&
                       (o_cmd == CMD_SIM_START || o_cmd == CMD_TIME_SYNC);

endmodule

// File: rtl/tor_slot_sync.sv
// tor_slot_sync: ToR-side slot timing. Follows SIM_START/TIME_SYNC from the
// OCS controller, times slot and guard windows, and meters the uplink byte budget.
module tor_slot_sync
    import ocs_ctrl_pkg::*;
#(
    parameter logic [47:0] P_MY_TOR_MAC        = 48'h8D_BC_5C_4A_00_00,
    parameter logic [31:0] P_CONFIG_DELAY      = 32'h0000_007D,
    parameter logic [31:0] P_SLOT_LEN          = 32'h0000_04E2,
    parameter logic [31:0] P_SLOT_MAX_BYTE_NUM = 32'h0000_2000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [63:0] i_ctrl_axis_data,
    input  logic [7:0]  i_ctrl_axis_keep,
    input  logic        i_ctrl_axis_valid,
    input  logic        i_ctrl_axis_last,
    input  logic        i_tx_byte_vld,
    input  logic [15:0] i_tx_byte_cnt,
    output logic        o_sim_start,
    output logic        o_slot_start,
    output logic [7:0]  o_slot_id,
    output logic        o_slot_active,
    output logic        o_tx_en,
    output logic [31:0] o_byte_credit,
    output logic        o_sync_err
);

    localparam logic [31:0] SLOT_LAST  = P_SLOT_LEN - 32'd1;
    localparam logic [31:0] GUARD_LAST = 2 * P_CONFIG_DELAY - 32'd1;

    slot_state_e state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] credit_q, credit_d;
    logic [7:0]  id_q, id_d;
    logic        sim_q, sim_d;
    logic        start_q, start_d;
    logic        err_q, err_d;
    logic        tx_en_q;
    logic        cmd_vld;
    logic [7:0]  cmd;
    logic [7:0]  cmd_id;
    logic        start;
    logic        unused_keep;

    assign unused_keep = ^i_ctrl_axis_keep;

    tor_ctrl_parser #(.P_MY_TOR_MAC(P_MY_TOR_MAC)) u_parser (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_data    (i_ctrl_axis_data),
        .i_valid   (i_ctrl_axis_valid),
        .i_last    (i_ctrl_axis_last),
        .o_cmd_vld (cmd_vld),
        .o_cmd     (cmd),
        .o_slot_id (cmd_id)
    );

    assign start = cmd_vld && (state_q == ST_IDLE ? cmd == CMD_SIM_START : cmd == CMD_TIME_SYNC);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 32'd1;
        credit_d = credit_q;
        id_d     = id_q;
        sim_d    = start && state_q == ST_IDLE;
        start_d  = start;
        err_d    = 1'b0;
        unique case (state_q)
            ST_IDLE:      cnt_d = cnt_q;
            ST_ACTIVE: begin
                err_d = start;
                if (cnt_q == SLOT_LAST) begin
                    state_d = ST_GUARD;
                    cnt_d   = 32'd0;
                end
            end
            ST_GUARD: begin
                if (cnt_q == GUARD_LAST) begin
                    state_d = ST_WAIT_SYNC;
                    cnt_d   = 32'd0;
                    err_d   = !start;
                end
            end
            ST_WAIT_SYNC: cnt_d = cnt_q;
            default:      state_d = ST_IDLE;
        endcase
        if (state_q == ST_ACTIVE && i_tx_byte_vld)
            credit_d = credit_q > {16'd0, i_tx_byte_cnt} ? credit_q - {16'd0, i_tx_byte_cnt} : 32'd0;
        // A slot start overrides both the terminal count and any byte report.
        if (start) begin
            state_d  = ST_ACTIVE;
            cnt_d    = 32'd0;
            id_d     = cmd_id;
            credit_d = P_SLOT_MAX_BYTE_NUM;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 32'd0;
            credit_q <= 32'd0;
            id_q     <= 8'h00;
            sim_q    <= 1'b0;
            start_q  <= 1'b0;
            err_q    <= 1'b0;
            tx_en_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            credit_q <= credit_d;
            id_q     <= id_d;
            sim_q    <= sim_d;
            start_q  <= start_d;
            err_q    <= err_d;
            tx_en_q  <= state_q == ST_ACTIVE && credit_q != 32'd0;
        end
    end

    assign o_sim_start   = sim_q;
    assign o_slot_start  = start_q;
    assign o_slot_id     = id_q;
    assign o_slot_active = state_q == ST_ACTIVE;
    assign o_tx_en       = tx_en_q;
    assign o_byte_credit = credit_q;
    assign o_sync_err    = err_q;

endmodule

// File: tb/tb_tor_slot_sync.sv
// tb_tor_slot_sync: directed bench for tor_slot_sync with hand-computed expectations.
module tb_tor_slot_sync;

    localparam logic [47:0] MY_MAC = 48'h8D_BC_5C_4A_00_00;
    localparam logic [47:0] BCAST  = 48'hFFFF_FFFF_FFFF;
    localparam logic [15:0] ET     = 16'h88B5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [63:0] data = '0;
    logic [7:0]  keep = '0;
    logic        valid = 1'b0;
    logic        last = 1'b0;
    logic        tx_vld = 1'b0;
    logic [15:0] tx_cnt = '0;
    logic        sim_start, slot_start, slot_active, tx_en, sync_err;
    logic [7:0]  slot_id;
    logic [31:0] credit;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    tor_slot_sync dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_ctrl_axis_data  (data),
        .i_ctrl_axis_keep  (keep),
        .i_ctrl_axis_valid (valid),
        .i_ctrl_axis_last  (last),
        .i_tx_byte_vld     (tx_vld),
        .i_tx_byte_cnt     (tx_cnt),
        .o_sim_start       (sim_start),
        .o_slot_start      (slot_start),
        .o_slot_id         (slot_id),
        .o_slot_active     (slot_active),
        .o_tx_en           (tx_en),
        .o_byte_credit     (credit),
        .o_sync_err        (sync_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [47:0] mac, input logic [15:0] et, input logic [7:0] cmd,
                              input logic [7:0] id, input int nb, input bit rpt);
        for (int b = 0; b < nb; b++) begin
            @(negedge clk);
            data   = b == 0 ? {mac, et} : (b == 1 ? {cmd, id, 48'h0} : 64'hDEAD_BEEF_0000_0000);
            keep   = 8'hFF;
            valid  = 1'b1;
            last   = b == nb - 1;
            tx_vld = rpt && b == nb - 1;
            tx_cnt = 16'd100;
        end
        @(negedge clk);
        valid  = 1'b0;
        last   = 1'b0;
        tx_vld = 1'b0;
    endtask

    task automatic report(input logic [15:0] n);
        @(negedge clk);
        tx_vld = 1'b1;
        tx_cnt = n;
        @(negedge clk);
        tx_vld = 1'b0;
    endtask

    task automatic skip(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 chk("rst_async", {sim_start, slot_start, slot_active, tx_en, sync_err, slot_id, credit}, '0);
        skip(3);
        rst_n = 1'b1;
        skip(1);
        chk("rst_state", {sim_start, slot_start, slot_active, tx_en, sync_err, slot_id, credit}, '0);

        send_frame(BCAST, ET, 8'h01, 8'h03, 2, 1'b0);
        chk("sim_pulse", {sim_start, slot_start, sync_err, slot_active}, 4'b1101);
        chk("sim_id", slot_id, 8'h03);
        chk("sim_credit", credit, 32'h2000);
        chk("sim_txen0", tx_en, 1'b0);
        skip(1);
        chk("sim_txen1", {tx_en, sim_start, slot_start}, 3'b100);
        skip(1248);
        chk("act_1249", slot_active, 1'b1);
        skip(1);
        chk("act_1250", slot_active, 1'b0);
        skip(1);
        chk("guard_txen", tx_en, 1'b0);
        skip(248);
        chk("err_249", sync_err, 1'b0);
        skip(1);
        chk("err_250", sync_err, 1'b1);
        skip(1);
        chk("err_251", {sync_err, slot_active, tx_en}, 3'b000);

        send_frame(MY_MAC, ET, 8'h02, 8'h09, 3, 1'b0);
        chk("wait_sync", {sim_start, slot_start, sync_err, slot_active, slot_id}, {4'b0101, 8'h09});
        send_frame(BCAST, ET, 8'h01, 8'h05, 2, 1'b0);
        chk("sim_ignored", {sim_start, slot_start, sync_err, slot_id}, {3'b000, 8'h09});
        report(16'd16);
        chk("early_pre_credit", credit, 32'h1FF0);
        send_frame(BCAST, ET, 8'h02, 8'h06, 2, 1'b1);
        chk("early_sync", {slot_start, sync_err, slot_id}, {2'b11, 8'h06});
        chk("reload_wins", credit, 32'h2000);

        send_frame(48'h8D_BC_5C_4A_00_01, ET, 8'h02, 8'h07, 2, 1'b0);
        chk("drop_mac", {sim_start, slot_start, sync_err, slot_id}, {3'b000, 8'h06});
        send_frame(BCAST, 16'h0800, 8'h02, 8'h07, 2, 1'b0);
        chk("drop_et", {sim_start, slot_start, sync_err, slot_id}, {3'b000, 8'h06});
        send_frame(BCAST, ET, 8'h02, 8'h07, 1, 1'b0);
        chk("drop_1beat", {sim_start, slot_start, sync_err, slot_id}, {3'b000, 8'h06});
        send_frame(BCAST, ET, 8'h07, 8'h07, 2, 1'b0);
        chk("drop_cmd", {sim_start, slot_start, sync_err, slot_id}, {3'b000, 8'h06});

        report(16'd1024);
        chk("credit_1", credit, 32'h1C00);
        for (int i = 0; i < 7; i++) report(16'd1024);
        chk("credit_0", credit, 32'h0);
        chk("txen_lag", tx_en, 1'b1);
        skip(1);
        chk("txen_drop", tx_en, 1'b0);
        report(16'd64);
        chk("credit_sat", credit, 32'h0);

        for (int i = 0; i < 1300 && slot_active; i++) @(negedge clk);
        chk("guard_reached", slot_active, 1'b0);
        skip(100);
        send_frame(BCAST, ET, 8'h02, 8'h04, 2, 1'b0);
        chk("guard_sync", {slot_start, sync_err, slot_active, slot_id}, {3'b101, 8'h04});
        chk("guard_credit", credit, 32'h2000);

        @(negedge clk);
        data  = {BCAST, ET};
        valid = 1'b1;
        last  = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        valid = 1'b0;
        #1 chk("rst_mid", {sim_start, slot_start, slot_active, tx_en, sync_err, slot_id, credit}, '0);
        skip(2);
        rst_n = 1'b1;
        skip(1);
        send_frame(BCAST, ET, 8'h01, 8'h11, 2, 1'b0);
        chk("post_rst_sim", {sim_start, slot_start, slot_active, slot_id}, {3'b111, 8'h11});
        chk("post_rst_credit", credit, 32'h2000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
